// File: rtl/snitch_icache_perf_ctr.sv
// Cluster-wide L0 instruction-cache event counters with a single-entry registered read port.
// Define SNITCH_ICACHE_PERF_OVF_IRQ_EN to add sticky saturation flags and an overflow interrupt.

module snitch_icache_perf_ctr_chk #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  input logic                 req_valid_i,
  input logic                 req_ready_o,
  input logic [2:0]           req_addr_i,
  input logic                 rsp_valid_o,
  input logic                 rsp_ready_i,
  input logic [CNT_WIDTH-1:0] rsp_data_o
);

  property p_req_addr_stable;
    @(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i && !req_ready_o) |=> $stable(req_addr_i);
  endproperty

  property p_rsp_data_stable;
    @(posedge clk_i) disable iff (!rst_ni)
      (rsp_valid_o && !rsp_ready_i) |=> $stable(rsp_data_o);
  endproperty

  a_req_addr_stable: assert property (p_req_addr_stable)
    else $error("req_addr_i changed while request stalled");
  a_rsp_data_stable: assert property (p_rsp_data_stable)
    else $error("rsp_data_o changed while response stalled");

endmodule

module snitch_icache_perf_ctr #(
  parameter int unsigned NR_FETCH_PORTS = 2,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NR_FETCH_PORTS-1:0][4:0] events_i,
  input  logic                           enable_i,
  input  logic                           clear_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [2:0]                     req_addr_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [CNT_WIDTH-1:0]           rsp_data_o,
`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
  output logic                           ovf_irq_o,
  output logic [5:0]                     ovf_mask_o,
`endif
  output logic                           rsp_err_o
);

  localparam int unsigned NR_CNT = 6;
  localparam int unsigned NR_EVT = 5;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Number of ports asserting one event bit, widened to the saturation-check width.
  function automatic logic [CNT_WIDTH:0] evt_popcount(input logic [NR_FETCH_PORTS-1:0] bits);
    logic [CNT_WIDTH:0] sum;
    sum = {(CNT_WIDTH+1){1'b0}};
    for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
      sum = sum + {{CNT_WIDTH{1'b0}}, bits[p]};
    end
    return sum;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [CNT_WIDTH:0]   inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + inc;
    if (sum > {1'b0, CNT_MAX}) begin
      return CNT_MAX;
    end else begin
      return sum[CNT_WIDTH-1:0];
    end
  endfunction

  logic [NR_EVT-1:0][NR_FETCH_PORTS-1:0] evt_bits_s;
  logic [NR_EVT-1:0][CNT_WIDTH:0]        evt_inc_s;
  logic [NR_CNT-1:0][CNT_WIDTH-1:0]      cnt_d, cnt_q;
  logic                                  rsp_valid_d, rsp_valid_q;
  logic [CNT_WIDTH-1:0]                  rsp_data_d, rsp_data_q;
  logic                                  rsp_err_d, rsp_err_q;
  logic                                  req_hs_s;

  // Regroup events per type so each counter sees one bit per fetch port.
  always_comb begin
    evt_bits_s = {(NR_EVT*NR_FETCH_PORTS){1'b0}};
    evt_inc_s  = {(NR_EVT*(CNT_WIDTH+1)){1'b0}};
    for (int unsigned k = 0; k < NR_EVT; k++) begin
      for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
        evt_bits_s[k][p] = events_i[p][k];
      end
      evt_inc_s[k] = evt_popcount(evt_bits_s[k]);
    end
  end

  // Counter next state: clear has priority over any increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {(NR_CNT*CNT_WIDTH){1'b0}};
    end else if (enable_i) begin
      for (int unsigned k = 0; k < NR_EVT; k++) begin
        cnt_d[k] = sat_add(cnt_q[k], evt_inc_s[k]);
      end
      cnt_d[NR_CNT-1] = sat_add(cnt_q[NR_CNT-1], {{CNT_WIDTH{1'b0}}, 1'b1});
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {(NR_CNT*CNT_WIDTH){1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign req_hs_s    = req_valid_i && req_ready_o;

  // Response next state: a new handshake reloads the register even while it is being drained.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (req_hs_s) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
      case (req_addr_i)
        3'd0:    rsp_data_d = cnt_q[0];
        3'd1:    rsp_data_d = cnt_q[1];
        3'd2:    rsp_data_d = cnt_q[2];
        3'd3:    rsp_data_d = cnt_q[3];
        3'd4:    rsp_data_d = cnt_q[4];
        3'd5:    rsp_data_d = cnt_q[5];
        default: begin
          rsp_data_d = {CNT_WIDTH{1'b0}};
          rsp_err_d  = 1'b1;
        end
      endcase
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Response register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {CNT_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
  logic [NR_CNT-1:0] sat_s;
  logic [NR_CNT-1:0] ovf_mask_d, ovf_mask_q;
  logic              ovf_irq_d, ovf_irq_q;

  // Flags latch from the registered counters, so they rise the cycle after saturation.
  always_comb begin
    sat_s      = {NR_CNT{1'b0}};
    ovf_mask_d = ovf_mask_q;
    ovf_irq_d  = ovf_irq_q;
    for (int unsigned k = 0; k < NR_CNT; k++) begin
      sat_s[k] = (cnt_q[k] == CNT_MAX);
    end
    if (clear_i) begin
      ovf_mask_d = {NR_CNT{1'b0}};
      ovf_irq_d  = 1'b0;
    end else begin
      ovf_mask_d = ovf_mask_q | sat_s;
      ovf_irq_d  = ovf_irq_q | (|sat_s);
    end
  end

  // Sticky overflow flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_mask_q <= {NR_CNT{1'b0}};
      ovf_irq_q  <= 1'b0;
    end else begin
      ovf_mask_q <= ovf_mask_d;
      ovf_irq_q  <= ovf_irq_d;
    end
  end

  assign ovf_mask_o = ovf_mask_q;
  assign ovf_irq_o  = ovf_irq_q;
`endif

  snitch_icache_perf_ctr_chk #(
    .CNT_WIDTH (CNT_WIDTH)
  ) i_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o)
  );

endmodule

// File: doc/snitch_icache_perf_ctr.md
Name: snitch_icache_perf_ctr

Overview:
- Event-counter stage directly downstream of the L0 instruction caches.
- Consumes one icache_l0_events_t per fetch port and accumulates cluster-wide counts of each event type, plus an enabled-cycle counter.
- Counters are read through a valid/ready request/response port, typically from a cluster peripheral register file.
- Software uses the counts for hit-rate and stall profiling.

Parameters:
- NR_FETCH_PORTS, 2, number of L0 caches / fetch ports feeding events.
- CNT_WIDTH, 32, width of each counter (>=8).
- Derived, not user-set: NR_CNT = 6, counter index: 0 miss, 1 hit, 2 prefetch, 3 double_hit, 4 stall, 5 cycles.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- events_i  in  NR_FETCH_PORTS x icache_l0_events_t (5 bits each)  per-port L0 event pulses, one cycle per event.
- enable_i  in  1  count only while high.
- clear_i  in  1  synchronous clear of all counters.
- req_valid_i  in  1  read request valid.
- req_ready_o  out  1  read request accepted.
- req_addr_i  in  3  counter index.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_data_o  out  CNT_WIDTH  counter value.
- rsp_err_o  out  1  index out of range (>=6).

Behaviour:
- Reset (rst_ni low, asynchronous): all counters 0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0. req_ready_o=1 once out of reset.

Counting:
- Each cycle with enable_i=1, counter k (k=0..4) adds popcount over ports of event bit k.
- Increment range is 0..NR_FETCH_PORTS; the sum is computed at CNT_WIDTH+1 bits.
- The cycle counter adds 1 each enabled cycle.
- All counters saturate at 2^CNT_WIDTH-1; they never wrap. A saturated counter stays saturated until cleared.
- enable_i=0: counters hold; events are ignored.
- clear_i=1: all counters are 0 next cycle. Clear wins over same-cycle increments, regardless of enable_i.

Read port:
- Single-entry response register.
- req_ready_o = !rsp_valid_o || rsp_ready_i, which allows back-to-back reads at full throughput.
- Handshake (req_valid_i && req_ready_o): next cycle rsp_valid_o=1, rsp_data_o = counter[req_addr_i] as registered at the handshake cycle (pre-increment, pre-clear), rsp_err_o=0.
- Out-of-range index: rsp_data_o=0, rsp_err_o=1.
- rsp_valid_o stays asserted with stable data/err until rsp_ready_i=1.
- rsp_valid_o deasserts after rsp_ready_i unless a new handshake happens in the same cycle, in which case it is reloaded.
- Read latency: exactly 1 cycle when unstalled.
- Reads do not disturb counting.
- Reset mid-transaction drops any pending response.

Assertions (simulation only):
- req_addr_i is stable while req_valid_i && !req_ready_o.
- rsp_data_o is stable while rsp_valid_o && !rsp_ready_i.

Optional Feature:
- Macro: SNITCH_ICACHE_PERF_OVF_IRQ_EN.
- Defined: adds output ovf_irq_o (1 bit, reset 0).
  - ovf_irq_o is set sticky in the cycle after any counter first reaches 2^CNT_WIDTH-1.
  - It is cleared only by clear_i or reset.
  - Also adds output ovf_mask_o (NR_CNT bits), a per-counter sticky saturated flag with the same clear rules.
- Undefined: neither port exists. Saturation behaviour is otherwise identical.

Test Plan:
- Reset, then read all indices 0..5 -> each response data 0, err 0. Read index 6 -> data 0, err 1.
- NR_FETCH_PORTS=2, enable=1 for 10 cycles with both ports l0_hit=1 and port0 l0_miss=1 -> hit=20, miss=10, cycles=10, others 0.
- Same stimulus with enable=0 for cycles 4..6 -> hit=14, miss=7, cycles=7.
- CNT_WIDTH=8: drive both ports l0_stall every cycle for 200 cycles -> stall reads 255 and stays 255 (no wrap).
  - With SNITCH_ICACHE_PERF_OVF_IRQ_EN: ovf_irq_o rises one cycle after the counter hits 255 and ovf_mask_o[4]=1.
- Issue read of cycles counter and assert clear_i in the same cycle with count=37 -> response 37. Next read -> 0 (or 1 if enabled since clear).
- Hold rsp_ready_i=0 for 5 cycles after a response -> rsp_valid_o and data stable, req_ready_o=0. Raise rsp_ready_i together with a new req_valid_i -> new response next cycle with no bubble.
